// File: rtl/cache_controller.sv
// Blocking-cache controller FSM: tag compare, dirty write-back and L2 refill.
// All outputs except state are combinational on the current state and inputs.
module cache_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld,
    input  logic        st,
    input  logic [31:0] addr,
    input  logic        valid,
    input  logic        dirty,
    input  logic [20:0] tag_loaded,
    input  logic        l2_ack,
    input  logic        write_done,
    output logic        hit,
    output logic        miss,
    output logic        load_ready,
    output logic        write_l1,
    output logic        write_l2,
    output logic        read_l2,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        COMPARE_TAG = 2'b01,
        ALLOCATE    = 2'b10,
        WRITE_BACK  = 2'b11
    } state_e;

    state_e state_q;
    state_e state_d;

    logic req;
    logic tag_hit;

    // Only the tag bits of the address matter here; index/offset are used by the datapath.
    logic unused_addr;
    assign unused_addr = ^addr[10:0];

    assign req     = ld | st;
    assign tag_hit = valid & (tag_loaded == addr[31:11]);

    // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        hit        = 1'b0;
        miss       = 1'b0;
        load_ready = 1'b0;
        write_l1   = 1'b0;
        write_l2   = 1'b0;
        read_l2    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = COMPARE_TAG;
                end
            end

            COMPARE_TAG: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (tag_hit) begin
                    hit        = 1'b1;
                    load_ready = ld;
                    write_l1   = st & ~ld;
                    state_d    = IDLE;
                end else begin
                    miss    = 1'b1;
                    state_d = (valid & dirty) ? WRITE_BACK : ALLOCATE;
                end
            end

            WRITE_BACK: begin
                write_l2 = 1'b1;
                if (write_done) begin
                    state_d = ALLOCATE;
                end
            end

            ALLOCATE: begin
                read_l2 = 1'b1;
                // Return to the compare so the freshly filled line is re-checked.
                if (l2_ack) begin
                    state_d = COMPARE_TAG;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller.
// Outputs are packed as {hit, miss, load_ready, write_l1, write_l2, read_l2}.
module tb_cache_controller;

    logic        clk;
    logic        reset;
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic        valid;
    logic        dirty;
    logic [20:0] tag_loaded;
    logic        l2_ack;
    logic        write_done;
    logic        hit;
    logic        miss;
    logic        load_ready;
    logic        write_l1;
    logic        write_l2;
    logic        read_l2;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_LDHIT = 6'b101000;
    localparam logic [5:0] O_STHIT = 6'b100100;
    localparam logic [5:0] O_MISS  = 6'b010000;
    localparam logic [5:0] O_WB    = 6'b000010;
    localparam logic [5:0] O_ALLOC = 6'b000001;

    cache_controller dut (
        .clk        (clk),
        .reset      (reset),
        .ld         (ld),
        .st         (st),
        .addr       (addr),
        .valid      (valid),
        .dirty      (dirty),
        .tag_loaded (tag_loaded),
        .l2_ack     (l2_ack),
        .write_done (write_done),
        .hit        (hit),
        .miss       (miss),
        .load_ready (load_ready),
        .write_l1   (write_l1),
        .write_l2   (write_l2),
        .read_l2    (read_l2),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {hit, miss, load_ready, write_l1, write_l2, read_l2};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_st(input string tag, input logic [1:0] s, input logic [5:0] o);
        check({tag, "_state"}, 32'(state), 32'(s));
        check({tag, "_outs"}, 32'(outs()), 32'(o));
    endtask

    initial begin
        reset      = 1'b1;
        ld         = 1'b0;
        st         = 1'b0;
        addr       = 32'h0000_1800;
        valid      = 1'b1;
        dirty      = 1'b0;
        tag_loaded = 21'h3;
        l2_ack     = 1'b0;
        write_done = 1'b0;

        #2;
        expect_st("reset", 2'b00, O_NONE);
        tick();
        tick();
        expect_st("reset_hold", 2'b00, O_NONE);
        reset = 1'b0;
        tick();
        expect_st("idle", 2'b00, O_NONE);

        // Read hit: tag of 0x1800 is 3
        ld = 1'b1;
        #1;
        expect_st("rdhit_idle", 2'b00, O_NONE);
        tick();
        expect_st("rdhit_cmp", 2'b01, O_LDHIT);
        ld = 1'b0;
        tick();
        expect_st("rdhit_done", 2'b00, O_NONE);

        // Write hit
        st = 1'b1;
        tick();
        expect_st("wrhit_cmp", 2'b01, O_STHIT);
        st = 1'b0;
        tick();
        expect_st("wrhit_done", 2'b00, O_NONE);

        // Load has priority over store
        ld = 1'b1;
        st = 1'b1;
        tick();
        expect_st("ldst_cmp", 2'b01, O_LDHIT);
        ld = 1'b0;
        st = 1'b0;
        tick();
        expect_st("ldst_done", 2'b00, O_NONE);

        // Request withdrawn in COMPARE_TAG
        ld = 1'b1;
        tick();
        ld = 1'b0;
        #1;
        expect_st("withdraw_cmp", 2'b01, O_NONE);
        tick();
        expect_st("withdraw_done", 2'b00, O_NONE);

        // Compulsory miss
        valid = 1'b0;
        ld    = 1'b1;
        tick();
        expect_st("cmiss_cmp", 2'b01, O_MISS);
        tick();
        expect_st("cmiss_alloc", 2'b10, O_ALLOC);
        tick();
        expect_st("cmiss_alloc_hold", 2'b10, O_ALLOC);
        l2_ack = 1'b1;
        valid  = 1'b1;
        tick();
        l2_ack = 1'b0;
        expect_st("cmiss_recmp", 2'b01, O_LDHIT);
        ld = 1'b0;
        tick();
        expect_st("cmiss_done", 2'b00, O_NONE);

        // Clean conflict miss
        tag_loaded = 21'h2;
        dirty      = 1'b0;
        ld         = 1'b1;
        tick();
        expect_st("clean_cmp", 2'b01, O_MISS);
        tick();
        expect_st("clean_alloc", 2'b10, O_ALLOC);
        l2_ack     = 1'b1;
        tag_loaded = 21'h3;
        tick();
        l2_ack = 1'b0;
        expect_st("clean_recmp", 2'b01, O_LDHIT);
        ld = 1'b0;
        tick();
        expect_st("clean_done", 2'b00, O_NONE);

        // Dirty conflict miss on a store
        tag_loaded = 21'h2;
        dirty      = 1'b1;
        st         = 1'b1;
        tick();
        expect_st("dirty_cmp", 2'b01, O_MISS);
        tick();
        expect_st("dirty_wb", 2'b11, O_WB);
        st   = 1'b0;
        addr = 32'hFFFF_F800;
        tick();
        expect_st("dirty_wb_ignore", 2'b11, O_WB);
        st         = 1'b1;
        addr       = 32'h0000_1800;
        write_done = 1'b1;
        tick();
        write_done = 1'b0;
        expect_st("dirty_alloc", 2'b10, O_ALLOC);
        l2_ack     = 1'b1;
        tag_loaded = 21'h3;
        dirty      = 1'b0;
        tick();
        l2_ack = 1'b0;
        expect_st("dirty_recmp", 2'b01, O_STHIT);
        st = 1'b0;
        tick();
        expect_st("dirty_done", 2'b00, O_NONE);

        // Asynchronous reset while in ALLOCATE
        valid = 1'b0;
        ld    = 1'b1;
        tick();
        tick();
        expect_st("rst_alloc_pre", 2'b10, O_ALLOC);
        #1;
        reset = 1'b1;
        #1;
        expect_st("rst_alloc_async", 2'b00, O_NONE);
        ld    = 1'b0;
        valid = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        expect_st("rst_alloc_after", 2'b00, O_NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports `clk` and `reset`.
REQ-002 `clk`  input  1  system clock; all state changes occur on the rising edge.
REQ-003 `reset`  input  1  asynchronous active-high reset; forces the FSM to IDLE.
REQ-004 `ld`  input  1  CPU load request, level-sensitive.
REQ-005 `st`  input  1  CPU store request, level-sensitive.
REQ-006 `addr`  input  32  CPU byte address; the request tag is `addr[31:11]`.
REQ-007 `valid`  input  1  valid bit of the L1 line selected by the index.
REQ-008 `dirty`  input  1  dirty bit of the selected L1 line.
REQ-009 `tag_loaded`  input  21  tag stored in the selected L1 line.
REQ-010 `l2_ack`  input  1  L2 has returned the requested block.
REQ-011 `write_done`  input  1  L2 has accepted the write-back of the victim block.
REQ-012 `hit`  output  1  tag compare succeeded this cycle.
REQ-013 `miss`  output  1  tag compare failed this cycle.
REQ-014 `load_ready`  output  1  load data in L1 is valid for the CPU.
REQ-015 `write_l1`  output  1  write the store data into L1.
REQ-016 `write_l2`  output  1  write the dirty victim block to L2.
REQ-017 `read_l2`  output  1  request a block read from L2.
REQ-018 `state`  output  2  current FSM state encoding.

Function
REQ-019 The FSM SHALL have four states: IDLE=2'b00, COMPARE_TAG=2'b01, ALLOCATE=2'b10, WRITE_BACK=2'b11; `state` SHALL equal the registered current state.
REQ-020 The compare SHALL be match = (`tag_loaded` == `addr[31:11]`), with `hit` = `valid` & match and `miss` = ~`hit`.
REQ-021 `hit` and `miss` SHALL be driven only in COMPARE_TAG while `ld`|`st` is asserted, and SHALL be 0 otherwise.
REQ-022 IDLE: if `ld`|`st`, next state is COMPARE_TAG; otherwise stay in IDLE; all outputs are 0.
REQ-023 COMPARE_TAG with hit: if `ld`, `load_ready`=1; else if `st`, `write_l1`=1; next state is IDLE.
REQ-024 When `ld` and `st` are both asserted, load SHALL take priority: `load_ready`=1 and `write_l1`=0.
REQ-025 COMPARE_TAG with miss and (`valid` & `dirty`): next state is WRITE_BACK.
REQ-026 COMPARE_TAG with miss and ~(`valid` & `dirty`): next state is ALLOCATE.
REQ-027 COMPARE_TAG with `ld`=`st`=0 (request withdrawn): next state is IDLE; all outputs are 0.
REQ-028 WRITE_BACK: `write_l2`=1 every cycle; on `write_done`=1 the next state is ALLOCATE; otherwise stay in WRITE_BACK.
REQ-029 ALLOCATE: `read_l2`=1 every cycle; on `l2_ack`=1 the next state is COMPARE_TAG, which re-checks the refilled line; otherwise stay in ALLOCATE.
REQ-030 WRITE_BACK and ALLOCATE SHALL ignore `ld`, `st` and `addr` changes.
REQ-031 All outputs except `state` SHALL be combinational functions of the current state and inputs; there SHALL be no extra latency.
REQ-032 An unreachable or illegal state SHALL NOT occur; the default branch SHALL go to IDLE.

Reset
REQ-033 While `reset`=1, the state SHALL be IDLE (`state`=2'b00) immediately, independent of `clk`.
REQ-034 While `reset`=1, all other outputs SHALL be 0.
REQ-035 Reset asserted mid-operation (WRITE_BACK or ALLOCATE) SHALL abort the transaction and return to IDLE.

Verification
REQ-036 Read hit: `addr`=0x00001800, `tag_loaded`=21'h3, `valid`=1, `ld`=1 -> `state` goes 00 then 01; `hit`=1, `load_ready`=1; the cycle after, `state`=00.
REQ-037 Write hit: same line, `st`=1 -> in COMPARE_TAG, `hit`=1, `write_l1`=1, `load_ready`=0; then IDLE.
REQ-038 Compulsory miss: `valid`=0, `ld`=1 -> `miss`=1 in 01, then 10 with `read_l2`=1 held until `l2_ack`=1 and `valid`=1; then 01 with `hit`=1, `load_ready`=1; then 00.
REQ-039 Clean conflict miss: `tag_loaded`=21'h2, `valid`=1, `dirty`=0, `ld`=1 -> 01 with `miss`=1, then 10 (`write_l2` never asserted); with `l2_ack`=1 and `tag_loaded`=21'h3, return to 01 with a hit.
REQ-040 Dirty conflict miss: `tag_loaded`=21'h2, `valid`=1, `dirty`=1, `st`=1 -> 01, then 11 with `write_l2`=1 until `write_done`=1; then 10 with `read_l2`=1; on `l2_ack`=1, then 01 with `hit`=1, `write_l1`=1; then 00.
REQ-041 Reset in ALLOCATE: assert `reset` while `state`=10 -> `state`=00 and `read_l2`=0 without waiting for a clock edge.
